// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl: ping-pong line memory that replays each active line
// together with its syncs and DE exactly one line period (HTOT clocks) later.
module line_buffer_ctrl #(
    parameter int HTOT = 15,
    parameter int HACT = 10
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_vsync,
    input  logic       i_hsync,
    input  logic       i_de,
    input  logic [9:0] i_r_data,
    input  logic [9:0] i_g_data,
    input  logic [9:0] i_b_data,
    output logic       o_vsync,
    output logic       o_hsync,
    output logic       o_de,
    output logic [9:0] o_r_data,
    output logic [9:0] o_g_data,
    output logic [9:0] o_b_data
);

    localparam int AW = (HACT > 1) ? $clog2(HACT) : 1;
    localparam logic [AW-1:0] ALAST = AW'(HACT - 1);

    // {vsync, hsync, de}; index 0 is one clock old
    logic [2:0]    sync_pipe [HTOT];

    logic [29:0]   mem [2][HACT];
    logic [29:0]   rd_word;
    logic          rd_ok;

    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic          wr_bank;
    logic [1:0]    written;
    logic          wr_arm;

    logic          de_prev;
    logic          de_fall;
    logic          wr_en;
    logic          rd_stb;
    logic          rd_bank;

    assign de_prev = sync_pipe[0][0];
    assign de_fall = de_prev & ~i_de;
    // wr_arm stays low until a blanking sample is seen after reset,
    // so a line already in progress at reset release is never stored
    assign wr_en   = i_de & wr_arm;
    assign rd_stb  = sync_pipe[HTOT-2][0];
    assign rd_bank = ~wr_bank;

    assign o_vsync = sync_pipe[HTOT-1][2];
    assign o_hsync = sync_pipe[HTOT-1][1];
    assign o_de    = sync_pipe[HTOT-1][0];

    assign {o_r_data, o_g_data, o_b_data} = rd_ok ? rd_word : 30'd0;

    // Sync/DE delay line of HTOT stages
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            for (int i = 0; i < HTOT; i++) begin
                sync_pipe[i] <= 3'b000;
            end
        end else begin
            sync_pipe[0] <= {i_vsync, i_hsync, i_de};
            for (int i = 1; i < HTOT; i++) begin
                sync_pipe[i] <= sync_pipe[i-1];
            end
        end
    end

    // Write address, bank ping-pong and per-bank written flags
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            wr_addr <= '0;
            wr_bank <= 1'b0;
            written <= 2'b00;
            wr_arm  <= 1'b0;
        end else begin
            if (!i_de) begin
                wr_arm <= 1'b1;
            end
            if (de_fall) begin
                wr_addr <= '0;
                if (wr_arm) begin
                    written[wr_bank] <= 1'b1;
                    wr_bank          <= ~wr_bank;
                end
            end else if (wr_en && (wr_addr != ALAST)) begin
                wr_addr <= wr_addr + 1'b1;
            end
        end
    end

    // Read address follows the delayed DE strobe, one clock ahead of o_de
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            rd_addr <= '0;
            rd_ok   <= 1'b0;
        end else begin
            rd_ok <= rd_stb & written[rd_bank];
            if (!rd_stb) begin
                rd_addr <= '0;
            end else if (rd_addr != ALAST) begin
                rd_addr <= rd_addr + 1'b1;
            end
        end
    end

    // Line memory: write the filling bank, read the other one
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_addr] <= {i_r_data, i_g_data, i_b_data};
        end
        rd_word <= mem[rd_bank][rd_addr];
    end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// tb_line_buffer_ctrl: drives framed video with random/ramp pixels and
// compares every output cycle against a line-level reference model.
module tb_line_buffer_ctrl;

    localparam int HTOT = 15;
    localparam int HACT = 10;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       i_vsync = 1'b0;
    logic       i_hsync = 1'b0;
    logic       i_de = 1'b0;
    logic [9:0] i_r_data = '0;
    logic [9:0] i_g_data = '0;
    logic [9:0] i_b_data = '0;
    logic       o_vsync;
    logic       o_hsync;
    logic       o_de;
    logic [9:0] o_r_data;
    logic [9:0] o_g_data;
    logic [9:0] o_b_data;

    always #5 clk = ~clk;

    line_buffer_ctrl #(.HTOT(HTOT), .HACT(HACT)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .i_vsync  (i_vsync),
        .i_hsync  (i_hsync),
        .i_de     (i_de),
        .i_r_data (i_r_data),
        .i_g_data (i_g_data),
        .i_b_data (i_b_data),
        .o_vsync  (o_vsync),
        .o_hsync  (o_hsync),
        .o_de     (o_de),
        .o_r_data (o_r_data),
        .o_g_data (o_g_data),
        .o_b_data (o_b_data)
    );

    typedef struct {
        logic vs;
        logic hs;
        logic de;
        int   line;
        int   pos;
        bit   clean;
    } ent_t;

    int          tests = 0;
    int          fails = 0;

    ent_t        hist[$];
    logic [29:0] words[$];
    int          n_line = -1;
    int          pos = 0;
    int          base = 0;
    bit          armed = 0;
    bit          prev_de = 0;
    bit          in_rst = 1;
    bit          cur_clean = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_vs"}, 32'(o_vsync), 32'd0);
        check({tag, "_hs"}, 32'(o_hsync), 32'd0);
        check({tag, "_de"}, 32'(o_de), 32'd0);
        check({tag, "_r"}, 32'(o_r_data), 32'd0);
        check({tag, "_g"}, 32'(o_g_data), 32'd0);
        check({tag, "_b"}, 32'(o_b_data), 32'd0);
    endtask

    task automatic step(input logic vs, input logic hs, input logic de,
                        input logic [9:0] r, input logic [9:0] g,
                        input logic [9:0] b);
        ent_t        e;
        ent_t        x;
        int          idx;
        int          k;
        logic [29:0] pix;
        i_vsync  = vs;
        i_hsync  = hs;
        i_de     = de;
        i_r_data = r;
        i_g_data = g;
        i_b_data = b;
        @(posedge clk);
        #1;
        e.vs = vs;
        e.hs = hs;
        e.de = de;
        e.line = 0;
        e.pos = 0;
        e.clean = 0;
        if (!in_rst) begin
            if (de) begin
                if (!prev_de) begin
                    n_line++;
                    pos = 0;
                    cur_clean = armed;
                    repeat (HACT) words.push_back(30'd0);
                end
                k = (pos < HACT - 1) ? pos : HACT - 1;
                words[n_line * HACT + k] = {r, g, b};
                e.line = n_line;
                e.pos = pos;
                e.clean = cur_clean;
                pos++;
            end else begin
                armed = 1;
            end
            prev_de = de;
        end
        hist.push_back(e);
        idx = hist.size() - HTOT;
        if (in_rst || idx < base) begin
            check_zero("idle");
        end else begin
            x = hist[idx];
            pix = 30'd0;
            if (x.de && x.clean) begin
                k = (x.pos < HACT - 1) ? x.pos : HACT - 1;
                pix = words[x.line * HACT + k];
            end
            check("vsync", 32'(o_vsync), 32'(x.vs));
            check("hsync", 32'(o_hsync), 32'(x.hs));
            check("de", 32'(o_de), 32'(x.de));
            check("r_data", 32'(o_r_data), 32'(pix[29:20]));
            check("g_data", 32'(o_g_data), 32'(pix[19:10]));
            check("b_data", 32'(o_b_data), 32'(pix[9:0]));
        end
    endtask

    task automatic rst_assert();
        #2;
        rstn = 1'b1;
        #1;
        check_zero("async_rst");
        in_rst = 1;
        armed = 0;
        prev_de = 0;
    endtask

    task automatic rst_release();
        #2;
        rstn = 1'b0;
        in_rst = 0;
        base = hist.size();
    endtask

    task automatic pixel(input int kind, input int lid, input int j,
                         output logic [9:0] r, output logic [9:0] g,
                         output logic [9:0] b);
        if (kind == 0) begin
            r = 10'(j + 1);
            g = 10'(j + 1);
            b = 10'(j + 1);
        end else if (kind == 1) begin
            r = 10'(lid * 16 + j);
            g = 10'($urandom);
            b = 10'($urandom);
        end else begin
            r = 10'($urandom);
            g = 10'($urandom);
            b = 10'($urandom);
        end
    endtask

    task automatic do_line(input logic vs, input int len, input int kind,
                           input int lid);
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
        logic       de;
        for (int s = 0; s < HTOT; s++) begin
            de = (s >= 3) && (s < 3 + len);
            r = '0;
            g = '0;
            b = '0;
            if (de) pixel(kind, lid, s - 3, r, g, b);
            step(vs, s == 0, de, r, g, b);
        end
    endtask

    task automatic do_frame(input int kind, input int fid);
        do_line(1'b1, 0, 0, 0);
        do_line(1'b0, 0, 0, 0);
        for (int l = 0; l < 4; l++) begin
            do_line(1'b0, HACT, (kind == 0 && l == 0) ? 0 : kind,
                    fid * 4 + l);
        end
        do_line(1'b0, 0, 0, 0);
    endtask

    initial begin
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
        logic       de;

        #20;
        check_zero("reset");
        repeat (3) step(1'b0, 1'b0, 1'b0, '0, '0, '0);
        rst_release();
        repeat (20) step(1'b0, 1'b0, 1'b0, '0, '0, '0);

        do_frame(0, 0);
        for (int f = 1; f <= 10; f++) do_frame(1, f);

        do_line(1'b0, HACT, 2, 0);
        for (int s = 0; s < HTOT; s++) begin
            de = (s >= 3) && (s < 3 + HACT);
            r = '0;
            g = '0;
            b = '0;
            if (de) pixel(2, 0, s - 3, r, g, b);
            step(1'b0, s == 0, de, r, g, b);
            if (s == 6) rst_assert();
            if (s == 9) rst_release();
        end
        do_line(1'b0, HACT, 2, 0);
        do_line(1'b0, HACT, 2, 0);
        do_line(1'b0, 0, 0, 0);

        do_line(1'b0, HACT + 2, 2, 0);
        do_line(1'b0, HACT, 2, 0);
        do_line(1'b0, 0, 0, 0);
        do_line(1'b0, 0, 0, 0);

        for (int f = 0; f < 2; f++) do_frame(2, f);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/line_buffer_ctrl.md
Name: line_buffer_ctrl

Overview:
Video line-buffer controller that sits between an upstream sync/pixel source and downstream video processing. It stores each active line of 3×10-bit RGB pixels in a ping-pong pair of line memories. It replays that line with syncs and DE exactly one line period (HTOT clocks) later. The output is a cycle-accurate, one-line-delayed copy of the input video stream.

Parameters:
- HTOT, default 15: horizontal total, in clocks per line; the output delay. Requires HTOT > HACT + 1.
- HACT, default 10: active pixels per line; depth of each line memory. Requires HACT ≥ 1.

Ports:
- clk, input, 1: pixel clock. Single clock domain.
- rstn, input, 1: reset. Asynchronous, active-high, despite the historical name.
- i_vsync, input, 1: input vertical sync. Polarity is passed through unchanged.
- i_hsync, input, 1: input horizontal sync. Polarity is passed through unchanged.
- i_de, input, 1: input data enable; high during active pixels.
- i_r_data, input, 10: input red pixel.
- i_g_data, input, 10: input green pixel.
- i_b_data, input, 10: input blue pixel.
- o_vsync, output, 1: i_vsync delayed HTOT clocks.
- o_hsync, output, 1: i_hsync delayed HTOT clocks.
- o_de, output, 1: i_de delayed HTOT clocks.
- o_r_data, output, 10: red pixel of the buffered line, aligned with o_de.
- o_g_data, output, 10: green pixel of the buffered line, aligned with o_de.
- o_b_data, output, 10: blue pixel of the buffered line, aligned with o_de.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- While reset is asserted, clear all of the following to 0: outputs, sync/DE delay pipelines, write and read addresses, bank select, and the written flags. Memory contents are not reset.
- Sync path: a shift register of depth HTOT carries {vsync, hsync, de}. o_* equals the input sampled exactly HTOT rising edges earlier.
- Memory: two banks (0/1), each HACT words × 30 bits ({r,g,b}). Writes and reads are synchronous, with 1-cycle read latency.
- Write side:
  - While i_de=1, write {r,g,b} to bank wr_bank at wr_addr, then increment wr_addr.
  - On the i_de falling edge (previous i_de=1, current i_de=0):
    - wr_addr resets to 0;
    - written[wr_bank] is set;
    - wr_bank toggles.
  - If i_de stays high for more than HACT clocks, wr_addr saturates at HACT-1 and later pixels overwrite the last word.
- Read side:
  - The read strobe is de delayed HTOT-1 clocks, taken from the shift-register tap.
  - While the strobe is high, read bank !wr_bank at rd_addr and increment rd_addr. rd_addr resets to 0 when the strobe falls.
  - The registered read data appears one clock later, coincident with o_de.
- Output data:
  - When o_de=1 and written[read bank]=1, o_*_data = the stored pixel.
  - Otherwise o_*_data = 0. This covers blanking and the first line after reset.
- Alignment: input line k, pixel j reappears on o_*_data in the same clock slot HTOT clocks later. Outputs keep that alignment indefinitely across lines and frames, with no vsync-based re-sync.
- The last active line of a frame is output during the following blanking line(s). This requires VFP ≥ 1 line for it to appear before the next frame's vsync.
- Simultaneous write and read use different banks, so there is no collision.
- Reset mid-line:
  - Outputs return to 0 immediately (asynchronously).
  - After release, the first line written is not replayed until its bank's written flag is set; partial lines are discarded.

Test Plan:
- Reset: hold rstn=1 for 20 ns, then clocks → all o_* = 0. After release with idle inputs, o_* stay 0.
- Sync delay: HTOT=15, HACT=10, stream frame timing HSW=1/HBP=2/HACT=10/HFP=2, VSW=1/VBP=1/VACT=4/VFP=1 → o_vsync/o_hsync/o_de equal the inputs delayed exactly 15 clocks on every cycle.
- Line replay: line 1 pixels R=G=B=1..10 → 15 clocks after each input pixel, o_r/g/b show 1..10 with o_de=1; zeros elsewhere.
- First line after reset: the first active line's replay window comes from a bank not yet written → o_de=1 with data 0. The next line is replayed correctly.
- Continuous run: 10 frames (10×7×15 clocks) with a per-line unique ramp (value = line×16 + pixel) → every output pixel matches its input 15 clocks earlier, with no drift; the last VACT line appears during the VFP line.
- Mid-line reset: assert rstn for 3 clocks mid-active-line → outputs go to 0 at once. After release, the next full line is replayed 15 clocks later and the partial line is not.
